// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache refill controller.
// A request is accepted in IDLE and looked up one cycle later. A miss fetches
// the whole line from backing memory in ascending word order, then returns
// the requested word. Flushes arriving mid-refill are deferred until the
// pending response has been delivered.
module icache_refill_ctrl #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;
    localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND} state_t;

    state_t           state;
    logic [31:2]      req_addr;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag_arr  [LINES];
    logic [31:0]      data_arr [LINES*WORDS];
    logic [OW-1:0]    beat_cnt;
    logic             flush_pend;

    logic [OW-1:0]    req_off;
    logic [IW-1:0]    req_idx;
    logic [TW-1:0]    req_tag;
    logic [31:0]      line_addr;
    logic             hit;
    logic             lookup_hit;
    logic             last_beat;
    logic [31:0]      rd_word;
    logic             unused_addr_bits;

    // Byte-lane bits of the fetch address carry no information for a word fetch.
    assign unused_addr_bits = ^fetch_addr[1:0];

    assign req_off   = req_addr[OW+1:2];
    assign req_idx   = req_addr[OW+IW+1:OW+2];
    assign req_tag   = req_addr[31:OW+IW+2];
    assign line_addr = {req_addr[31:OW+2], {(OW+2){1'b0}}};
    assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign rd_word   = data_arr[{req_idx, req_off}];
    assign last_beat = mem_rvalid && (beat_cnt == LAST_BEAT);

    // A flush in IDLE takes priority over a new request, so hold off acceptance.
    assign fetch_ready = (state == IDLE) && !flush;
    // A flush in LOOKUP turns a would-be hit into a miss.
    assign lookup_hit  = (state == LOOKUP) && hit && !flush;
    assign fetch_valid = lookup_hit || (state == RESPOND);
    // Drive zero when idle so the bus never shows uninitialised array contents.
    assign fetch_instr = fetch_valid ? rd_word : 32'd0;
    assign mem_req     = (state == MISS_REQ);

    // Control FSM: request latch, valid bits, refill beat counter, deferred flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_addr   <= '0;
            valid      <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (fetch_req) begin
                        req_addr <= fetch_addr[31:2];
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        valid    <= '0;
                        mem_addr <= line_addr;
                        state    <= MISS_REQ;
                    end else if (hit) begin
                        state <= IDLE;
                    end else begin
                        mem_addr <= line_addr;
                        state    <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        // The line is about to be overwritten word by word;
                        // keep it invalid until the final beat lands.
                        valid[req_idx] <= 1'b0;
                        beat_cnt       <= '0;
                        state          <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + OW'(1);
                    end
                    if (last_beat) begin
                        valid[req_idx] <= 1'b1;
                        state          <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (flush || flush_pend) begin
                        valid <= '0;
                    end
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage: written only by refill beats, never reset.
    always_ff @(posedge clock) begin
        if ((state == REFILL) && mem_rvalid) begin
            data_arr[{req_idx, beat_cnt}] <= mem_rdata;
            if (beat_cnt == LAST_BEAT) begin
                tag_arr[req_idx] <= req_tag;
            end
        end
    end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINES, 8, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter WORDS, 4, 32-bit instruction words per line (power of 2).
REQ-003 SHALL have port clock input 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset input 1, synchronous, active-high.
REQ-005 SHALL have port fetch_req input 1, core requests an instruction.
REQ-006 SHALL have port fetch_addr input 32, byte address; bits [1:0] ignored.
REQ-007 SHALL have port fetch_ready output 1, controller can accept a request this cycle.
REQ-008 SHALL have port fetch_valid output 1, fetch_instr valid this cycle.
REQ-009 SHALL have port fetch_instr output 32, returned instruction.
REQ-010 SHALL have port flush input 1, invalidate all lines.
REQ-011 SHALL have port mem_req output 1, line read request to backing memory.
REQ-012 SHALL have port mem_addr output 32, line-aligned byte address of refill.
REQ-013 SHALL have port mem_ack input 1, memory accepted request.
REQ-014 SHALL have port mem_rvalid input 1, one refill word present on mem_rdata.
REQ-015 SHALL have port mem_rdata input 32, refill word, delivered in ascending word order.

Function
REQ-016 SHALL split address as offset=addr[log2(WORDS)+1:2], index=next log2(LINES) bits, tag=remaining upper bits.
REQ-017 SHALL hold per line a valid bit, tag, WORDS data words.
REQ-018 SHALL implement states IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
REQ-019 SHALL assert fetch_ready only in IDLE; request accepted when fetch_req && fetch_ready, latching fetch_addr, next state LOOKUP.
REQ-020 In LOOKUP on hit (valid && tag match) SHALL assert fetch_valid with the addressed word that cycle (1-cycle latency from acceptance) and return to IDLE.
REQ-021 In LOOKUP on miss SHALL go to MISS_REQ with fetch_valid low.
REQ-022 In MISS_REQ SHALL hold mem_req=1 and mem_addr=latched address with offset and bits [1:0] zeroed, stable until mem_ack; on mem_req && mem_ack go to REFILL, mem_req low next cycle.
REQ-023 In REFILL SHALL write each mem_rvalid word to the line at a 2-bit-wide (log2 WORDS) word counter, counter starting 0 and incrementing per beat; cycles without mem_rvalid SHALL hold state.
REQ-024 On the beat with counter=WORDS-1 SHALL write tag, set valid, go to RESPOND.
REQ-025 In RESPOND SHALL assert fetch_valid for one cycle with the latched-offset word from the refilled line, then go to IDLE.
REQ-026 fetch_valid SHALL be high only in LOOKUP-hit and RESPOND cycles, never two consecutive cycles.
REQ-027 A write into the line and same-line read in RESPOND SHALL return the new data (no stale word).
REQ-028 flush in IDLE or LOOKUP SHALL clear all valid bits at that edge and force LOOKUP to be treated as miss; state goes/stays IDLE if in IDLE, MISS_REQ if in LOOKUP.
REQ-029 flush during MISS_REQ/REFILL/RESPOND SHALL be recorded and applied (all valids cleared, including the refilled line) on the RESPOND-to-IDLE edge; the pending response still completes.
REQ-030 fetch_req while fetch_ready low SHALL be ignored; the core holds it.

Reset
REQ-031 On reset SHALL enter IDLE, clear all valid bits, word counter and pending flush; outputs next cycle: fetch_ready=1, fetch_valid=0, fetch_instr=0, mem_req=0, mem_addr=0.
REQ-032 Reset mid-refill SHALL abandon the refill, leave the line invalid and ignore subsequent mem_rvalid until a new request.
REQ-033 Data array contents SHALL not require reset.

Verification
REQ-034 Cold miss: reset, fetch 0x00000008 -> mem_req with mem_addr=0x00000000; 4 beats 0x11,0x22,0x33,0x44 -> RESPOND fetch_instr=0x33.
REQ-035 Hit: then fetch 0x0000000C -> fetch_valid cycle after acceptance, fetch_instr=0x44, no mem_req.
REQ-036 Conflict: fetch 0x00000080 (same index 0, new tag) -> refill at 0x00000080; later fetch 0x00000000 misses again.
REQ-037 Stalls: mem_ack delayed 3 cycles and gaps between mem_rvalid beats -> mem_addr stable, data correct, fetch_ready low throughout.
REQ-038 Flush: flush during REFILL -> response delivered, next fetch to same address misses.
REQ-039 Reset after 2 of 4 beats -> IDLE, fetch_ready=1; refetch same address issues a new mem_req.
